jtopl_eg_slot: RTL and testbench

- Time-multiplexed envelope-generator state stage for the OPL2 core.
- Owns the global 15-bit EG counter, the per-operator ADSR state and the 9-bit attenuation for SLOTS operators.
- Each active cycle it drives one slot's base_rate/attack/cnt_in to the rate-step stage and consumes that stage's step/rate/sum_up combinationally in the same cycle.
- It writes back the updated attenuation, which feeds the operator level stage.

---
 rtl/jtopl_eg_slot_pkg.sv | 50 +++++
 rtl/jtopl_eg_slot_if.sv | 31 +++
 rtl/jtopl_eg_att_upd.sv | 108 ++++++++++
 rtl/jtopl_eg_slot.sv | 149 ++++++++++++++
 tb/tb_jtopl_eg_slot.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jtopl_eg_slot_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jtopl_eg_slot_pkg
// Shared definitions for the OPL2 envelope-generator state stage:
//   - ADSR state encoding (ATTACK=0, DECAY=1, SUSTAIN=2, RELEASE=3)
//   - default operator count, attenuation and EG counter widths
//   - the full-silence attenuation constant
//   - small helpers for the sustain-level threshold and decay step size
// ---------------------------------------------------------------------------
package jtopl_eg_slot_pkg;

    typedef enum logic [1:0] {
        EG_ATTACK  = 2'd0,
        EG_DECAY   = 2'd1,
        EG_SUSTAIN = 2'd2,
        EG_RELEASE = 2'd3
    } eg_state_t;

    localparam int SLOTS_DEF = 18;
    localparam int ATT_W     = 9;
    localparam int CNT_W     = 15;

    localparam logic [ATT_W-1:0] ATT_SILENT = 9'h1FF;

    // Sustain level 15 means "almost silent": compare against the top of the
    // attenuation range instead of 15<<4.
    function automatic logic [4:0] sl_expand(input logic [3:0] sl);
        logic [4:0] slx;
        if (sl == 4'd15) begin
            slx = 5'h1F;
        end else begin
            slx = {1'b0, sl};
        end
        return slx;
    endfunction

    // Attenuation increment for the non-attack phases, keyed on rate[5:2].
    // Rates below 13 move one unit per step; the top three double each time.
    function automatic logic [3:0] decay_inc(input logic [3:0] rate_hi);
        logic [3:0] inc;
        case (rate_hi)
            4'd13:   inc = 4'd2;
            4'd14:   inc = 4'd4;
            4'd15:   inc = 4'd8;
            default: inc = 4'd1;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/jtopl_eg_slot_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jtopl_eg_slot_if
// Bus between the EG state stage and the EG rate-step stage.
//   master (EG state stage) drives : eg_cnt, base_rate, attack, cnt_in
//   slave  (rate-step stage) drives : step, rate, sum_up, cnt_lsb
// The step stage answers combinationally within the same cycle.
// ---------------------------------------------------------------------------
interface jtopl_eg_slot_if;
    import jtopl_eg_slot_pkg::*;

    logic [CNT_W-1:0] eg_cnt;     // global envelope counter
    logic [4:0]       base_rate;  // selected rate, 0 or {r,0}
    logic             attack;     // serviced slot is in ATTACK
    logic             cnt_in;     // stored counter LSB of serviced slot
    logic             step;       // step stage: this visit may step
    logic [5:0]       rate;       // step stage: effective rate
    logic             sum_up;     // step stage: EG bit toggled since last visit
    logic             cnt_lsb;    // step stage: LSB to store for this slot

    modport master (
        output eg_cnt, base_rate, attack, cnt_in,
        input  step, rate, sum_up, cnt_lsb
    );

    modport slave (
        input  eg_cnt, base_rate, attack, cnt_in,
        output step, rate, sum_up, cnt_lsb
    );

endinterface

// File: rtl/jtopl_eg_att_upd.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jtopl_eg_att_upd
// Purely combinational read-modify-write core for one operator slot:
// computes the next ADSR state and next attenuation.
//   state, att     : stored state/attenuation of the serviced slot
//   rate_hi        : rate[5:2] from the step stage
//   step, sum_up   : step-stage qualifiers; attenuation moves only when both set
//   keyon, kon_edge: current key-on and its rising edge versus the stored value
//   sl             : sustain level
//   state_next, att_next : values to write back
// ---------------------------------------------------------------------------
module jtopl_eg_att_upd
    import jtopl_eg_slot_pkg::*;
(
    input  eg_state_t        state,
    input  logic [ATT_W-1:0] att,
    input  logic [3:0]       rate_hi,
    input  logic             step,
    input  logic             sum_up,
    input  logic             keyon,
    input  logic             kon_edge,
    input  logic [3:0]       sl,
    output eg_state_t        state_next,
    output logic [ATT_W-1:0] att_next
);

    logic             stepped_s;
    logic             rate_max_s;
    logic [ATT_W:0]   att_dec_s;
    logic [ATT_W:0]   att_inc_s;

    assign stepped_s  = step & sum_up;
    assign rate_max_s = (rate_hi == 4'd15);

    // Candidate attenuations for both directions, one bit wider to expose
    // underflow/overflow.
    always_comb begin
        att_dec_s = {1'b0, att} - {4'd0, att[ATT_W-1:3]} - 10'd1;
        att_inc_s = {1'b0, att} + {6'd0, decay_inc(rate_hi)};
    end

    // Next attenuation: a key-on edge only resets the level at the maximum
    // rate; otherwise attack shrinks exponentially and the other phases
    // grow linearly with saturation at silence.
    always_comb begin
        att_next = att;
        if (kon_edge) begin
            if (rate_max_s) begin
                att_next = 9'd0;
            end else begin
                att_next = att;
            end
        end else if (state == EG_ATTACK) begin
            if (rate_max_s) begin
                att_next = 9'd0;
            end else if (stepped_s) begin
                // att - (att>>3) - 1 only underflows when att is already 0
                if (att == 9'd0) begin
                    att_next = 9'd0;
                end else begin
                    att_next = att_dec_s[ATT_W-1:0];
                end
            end else begin
                att_next = att;
            end
        end else if (stepped_s) begin
            if (att_inc_s[ATT_W]) begin
                att_next = ATT_SILENT;
            end else begin
                att_next = att_inc_s[ATT_W-1:0];
            end
        end else begin
            att_next = att;
        end
    end

    // Next ADSR state: key-on edge wins over everything, key-off forces
    // release, then the level-driven attack->decay->sustain progression
    // evaluated on the stored attenuation.
    always_comb begin
        state_next = state;
        if (kon_edge) begin
            state_next = EG_ATTACK;
        end else if (!keyon && (state != EG_RELEASE)) begin
            state_next = EG_RELEASE;
        end else begin
            case (state)
                EG_ATTACK: begin
                    if (att == 9'd0) begin
                        state_next = EG_DECAY;
                    end else begin
                        state_next = EG_ATTACK;
                    end
                end
                EG_DECAY: begin
                    if (att[ATT_W-1:4] >= sl_expand(sl)) begin
                        state_next = EG_SUSTAIN;
                    end else begin
                        state_next = EG_DECAY;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

endmodule

// File: rtl/jtopl_eg_slot.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jtopl_eg_slot
// Time-multiplexed envelope-generator state stage for the OPL2 core.
// Services one operator slot per cen cycle in round-robin order, owns the
// global 15-bit EG counter and the per-slot ADSR state / attenuation.
//   clk, rst        : clock, synchronous active-high reset (priority over cen)
//   cen             : clock enable; all state advances only when high
//   keyon, ar, dr, sl, rr, eg_type : operator parameters of the current slot
//   slot            : index of the slot serviced this cycle
//   sbus (master)   : rate-step stage bus (eg_cnt/base_rate/attack/cnt_in out,
//                     step/rate/sum_up/cnt_lsb in, same-cycle response)
//   eg_att, eg_slot : attenuation written back for the slot serviced in the
//                     previous cen cycle, and that slot's index
// ---------------------------------------------------------------------------
module jtopl_eg_slot
    import jtopl_eg_slot_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             keyon,
    input  logic [3:0]       ar,
    input  logic [3:0]       dr,
    input  logic [3:0]       sl,
    input  logic [3:0]       rr,
    input  logic             eg_type,
    output logic [4:0]       slot,
    jtopl_eg_slot_if.master  sbus,
    output logic [ATT_W-1:0] eg_att,
    output logic [4:0]       eg_slot
);

    localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

    // Slot memory
    eg_state_t        state_mem_r [0:SLOTS-1];
    logic [ATT_W-1:0] att_mem_r   [0:SLOTS-1];
    logic [SLOTS-1:0] kon_mem_r;
    logic [SLOTS-1:0] lsb_mem_r;

    logic [4:0]       slot_r;
    logic [CNT_W-1:0] eg_cnt_r;
    logic [ATT_W-1:0] eg_att_r;
    logic [4:0]       eg_slot_r;

    eg_state_t        cur_state_s;
    logic [ATT_W-1:0] cur_att_s;
    logic             cur_kon_s;
    logic             cur_lsb_s;
    logic             kon_edge_s;
    logic [3:0]       rate_sel_s;
    eg_state_t        state_next_s;
    logic [ATT_W-1:0] att_next_s;
    logic             rate_lo_unused_s;

    // Fetch the serviced slot's stored context
    always_comb begin
        cur_state_s = state_mem_r[slot_r];
        cur_att_s   = att_mem_r[slot_r];
        cur_kon_s   = kon_mem_r[slot_r];
        cur_lsb_s   = lsb_mem_r[slot_r];
    end

    assign kon_edge_s = keyon & ~cur_kon_s;

    // Phase-dependent rate; a held sustain (eg_type=1) never steps
    always_comb begin
        rate_sel_s = 4'd0;
        case (cur_state_s)
            EG_ATTACK:  rate_sel_s = ar;
            EG_DECAY:   rate_sel_s = dr;
            EG_SUSTAIN: rate_sel_s = eg_type ? 4'd0 : rr;
            EG_RELEASE: rate_sel_s = rr;
            default:    rate_sel_s = rr;
        endcase
    end

    assign sbus.base_rate = (rate_sel_s == 4'd0) ? 5'd0 : {rate_sel_s, 1'b0};
    assign sbus.attack    = (cur_state_s == EG_ATTACK);
    assign sbus.cnt_in    = cur_lsb_s;
    assign sbus.eg_cnt    = eg_cnt_r;

    // The two fractional rate bits are consumed inside the step stage only
    assign rate_lo_unused_s = ^sbus.rate[1:0];

    jtopl_eg_att_upd u_att_upd (
        .state      (cur_state_s),
        .att        (cur_att_s),
        .rate_hi    (sbus.rate[5:2]),
        .step       (sbus.step),
        .sum_up     (sbus.sum_up),
        .keyon      (keyon),
        .kon_edge   (kon_edge_s),
        .sl         (sl),
        .state_next (state_next_s),
        .att_next   (att_next_s)
    );

    // Round-robin slot pointer; the EG counter ticks once per full round
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r   <= 5'd0;
            eg_cnt_r <= 15'd0;
        end else if (cen) begin
            if (slot_r == LAST_SLOT) begin
                slot_r   <= 5'd0;
                eg_cnt_r <= eg_cnt_r + 15'd1;
            end else begin
                slot_r   <= slot_r + 5'd1;
            end
        end
    end

    // Write back the serviced slot's context
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                state_mem_r[i] <= EG_RELEASE;
                att_mem_r[i]   <= ATT_SILENT;
            end
            kon_mem_r <= {SLOTS{1'b0}};
            lsb_mem_r <= {SLOTS{1'b0}};
        end else if (cen) begin
            state_mem_r[slot_r] <= state_next_s;
            att_mem_r[slot_r]   <= att_next_s;
            kon_mem_r[slot_r]   <= keyon;
            lsb_mem_r[slot_r]   <= sbus.cnt_lsb;
        end
    end

    // Registered attenuation output towards the operator level stage
    always_ff @(posedge clk) begin
        if (rst) begin
            eg_att_r  <= ATT_SILENT;
            eg_slot_r <= 5'd0;
        end else if (cen) begin
            eg_att_r  <= att_next_s;
            eg_slot_r <= slot_r;
        end
    end

    assign slot    = slot_r;
    assign eg_att  = eg_att_r;
    assign eg_slot = eg_slot_r;

endmodule

// File: tb/tb_jtopl_eg_slot.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_jtopl_eg_slot
// Scoreboard bench: a driver plays the operator register file and the
// rate-step stage, advances a behavioural ADSR model and queues the expected
// outputs; a monitor pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_jtopl_eg_slot;

    localparam int NS = 18;

    logic       clk;
    logic       rst, cen, keyon, eg_type;
    logic [3:0] ar, dr, sl, rr;
    logic [4:0] slot, eg_slot;
    logic [8:0] eg_att;

    jtopl_eg_slot_if sbus();

    jtopl_eg_slot #(.SLOTS(NS)) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .keyon   (keyon),
        .ar      (ar),
        .dr      (dr),
        .sl      (sl),
        .rr      (rr),
        .eg_type (eg_type),
        .slot    (slot),
        .sbus    (sbus.master),
        .eg_att  (eg_att),
        .eg_slot (eg_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int slot;
        int cnt;
        int base_rate;
        int attack;
        int cnt_in;
        int p_att;
        int p_egslot;
        int p_slot;
        int p_cnt;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: states 0=attack 1=decay 2=sustain 3=release
    int m_state[NS];
    int m_att[NS];
    int m_kon[NS];
    int m_lsb[NS];
    int m_slot, m_cnt, m_eg_att, m_eg_slot;

    // operator register file seen by the DUT
    int k_a[NS], ar_a[NS], dr_a[NS], sl_a[NS], rr_a[NS], egt_a[NS];

    int directed;   // 1: step on every visit with a nonzero rate
    int fixed_sum;  // sum_up value in directed mode

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_state[i] = 3;
            m_att[i]   = 511;
            m_kon[i]   = 0;
            m_lsb[i]   = 0;
        end
        m_slot = 0; m_cnt = 0; m_eg_att = 511; m_eg_slot = 0;
    endfunction

    function automatic void rand_slot(input int s);
        k_a[s]   = int'($urandom_range(0, 3) != 0);
        ar_a[s]  = int'($urandom_range(0, 15));
        dr_a[s]  = int'($urandom_range(0, 15));
        sl_a[s]  = int'($urandom_range(0, 15));
        rr_a[s]  = int'($urandom_range(0, 15));
        egt_a[s] = int'($urandom_range(0, 1));
    endfunction

    // One cen-cycle of stimulus plus the reference model update
    task automatic drive_cycle(input bit do_rst, input bit do_cen);
        exp_t e;
        int s, st, a, r4, br, rh, kon, kedge, stepped, na, nst, slx, inc;
        @(negedge clk);
        s  = m_slot;
        st = m_state[s];
        a  = m_att[s];
        rst = do_rst; cen = do_cen;
        keyon = k_a[s][0];
        ar = 4'(ar_a[s]); dr = 4'(dr_a[s]); sl = 4'(sl_a[s]); rr = 4'(rr_a[s]);
        eg_type = egt_a[s][0];
        if (st == 0)      r4 = ar_a[s];
        else if (st == 1) r4 = dr_a[s];
        else if (st == 2) r4 = (egt_a[s] != 0) ? 0 : rr_a[s];
        else              r4 = rr_a[s];
        br = (r4 == 0) ? 0 : 2 * r4;
        // emulated step stage: effective rate is 4*r plus a key-scale offset
        sbus.rate    = (r4 == 0) ? 6'd0 : 6'(4 * r4 + int'($urandom_range(0, 3)));
        if (directed != 0) begin
            sbus.step   = (r4 != 0);
            sbus.sum_up = fixed_sum[0];
        end else begin
            sbus.step   = 1'($urandom_range(0, 1));
            sbus.sum_up = ($urandom_range(0, 3) != 0);
        end
        sbus.cnt_lsb = 1'($urandom_range(0, 1));

        e.slot = m_slot; e.cnt = m_cnt; e.base_rate = br;
        e.attack = (st == 0) ? 1 : 0; e.cnt_in = m_lsb[s];

        if (do_rst) begin
            model_reset();
        end else if (do_cen) begin
            rh      = int'(sbus.rate) / 4;
            kon     = k_a[s];
            kedge   = (kon != 0 && m_kon[s] == 0) ? 1 : 0;
            stepped = (sbus.step && sbus.sum_up) ? 1 : 0;
            slx     = (sl_a[s] == 15) ? 31 : sl_a[s];
            na = a; nst = st;
            if (kedge != 0) begin
                nst = 0;
                if (rh == 15) na = 0;
            end else begin
                if (st == 0) begin
                    if (rh == 15) na = 0;
                    else if (stepped != 0) begin
                        na = a - a / 8 - 1;
                        if (na < 0) na = 0;
                    end
                end else if (stepped != 0) begin
                    inc = (rh < 13) ? 1 : (1 << (rh - 12));
                    na = a + inc;
                    if (na > 511) na = 511;
                end
                if (kon == 0 && st != 3) nst = 3;
                else if (st == 0 && a == 0) nst = 1;
                else if (st == 1 && a / 16 >= slx) nst = 2;
            end
            m_state[s] = nst; m_att[s] = na; m_kon[s] = kon;
            m_lsb[s] = int'(sbus.cnt_lsb);
            m_eg_att = na; m_eg_slot = s;
            if (s == NS - 1) m_cnt = (m_cnt + 1) % 32768;
            m_slot = (s + 1) % NS;
        end
        e.p_att = m_eg_att; e.p_egslot = m_eg_slot;
        e.p_slot = m_slot; e.p_cnt = m_cnt;
        q.push_back(e);
        n_vec++;
    endtask

    // Monitor: combinational step-stage outputs before the edge, registered
    // outputs just after it
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                e = q[0];
                chk("slot_pre", int'(slot), e.slot);
                chk("eg_cnt_pre", int'(sbus.eg_cnt), e.cnt);
                chk("base_rate", int'(sbus.base_rate), e.base_rate);
                chk("attack", int'(sbus.attack), e.attack);
                chk("cnt_in", int'(sbus.cnt_in), e.cnt_in);
                @(posedge clk);
                #1;
                e = q.pop_front();
                chk("eg_att", int'(eg_att), e.p_att);
                chk("eg_slot", int'(eg_slot), e.p_egslot);
                chk("slot_post", int'(slot), e.p_slot);
                chk("eg_cnt_post", int'(sbus.eg_cnt), e.p_cnt);
            end
        end
    end

    initial begin : driver
        bit rst_done;
        rst = 1'b1; cen = 1'b0; keyon = 1'b0; eg_type = 1'b0;
        ar = 4'd0; dr = 4'd0; sl = 4'd0; rr = 4'd0;
        sbus.step = 1'b0; sbus.rate = 6'd0; sbus.sum_up = 1'b0; sbus.cnt_lsb = 1'b0;
        for (int i = 0; i < NS; i++) begin
            k_a[i] = 0; ar_a[i] = 0; dr_a[i] = 0; sl_a[i] = 0; rr_a[i] = 0; egt_a[i] = 0;
        end
        model_reset();
        directed = 0; fixed_sum = 1;
        @(posedge clk);

        // reset with cen high, then three idle rounds
        drive_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3 * NS; i++) drive_cycle(1'b0, 1'b1);

        // slot 0: instant attack, decay to sl=2, held sustain
        // slot 1: stepped attack from silence down to zero
        directed = 1; fixed_sum = 1;
        k_a[0] = 1; ar_a[0] = 15; dr_a[0] = 3; sl_a[0] = 2; rr_a[0] = 15; egt_a[0] = 1;
        k_a[1] = 1; ar_a[1] = 4;  dr_a[1] = 0; sl_a[1] = 0; rr_a[1] = 7;  egt_a[1] = 0;
        for (int i = 0; i < 40 * NS; i++) drive_cycle(1'b0, 1'b1);

        // key-off: first rounds without sum_up, then fast release to silence
        k_a[0] = 0; k_a[1] = 0; fixed_sum = 0;
        for (int i = 0; i < 5 * NS; i++) drive_cycle(1'b0, 1'b1);
        fixed_sum = 1;
        for (int i = 0; i < 70 * NS; i++) drive_cycle(1'b0, 1'b1);

        // randomized traffic with gated cen and one mid-round reset at slot 7
        directed = 0;
        for (int s = 0; s < NS; s++) rand_slot(s);
        rst_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rand_slot(int'($urandom_range(0, NS - 1)));
            if (!rst_done && i > 1500 && m_slot == 7) begin
                drive_cycle(1'b1, 1'b1);
                rst_done = 1'b1;
            end else begin
                drive_cycle(1'b0, ($urandom_range(0, 6) != 0));
            end
        end

        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
